// File: rtl/sobel_stream_gradient_if.sv
// Pixel-in / gradient-out stream bundle for the streaming Sobel stage.
// The slave side is the gradient block; the master side feeds pixels and consumes results.
interface sobel_stream_gradient_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_pixel;
  logic              in_sof;
  logic              out_valid;
  logic [DATA_W-1:0] out_grad;
  logic              out_edge;
  logic              out_sat;
  logic              out_eol;

  modport slave (
    input  in_valid, in_pixel, in_sof,
    output out_valid, out_grad, out_edge, out_sat, out_eol
  );

  modport master (
    output in_valid, in_pixel, in_sof,
    input  out_valid, out_grad, out_edge, out_sat, out_eol
  );
endinterface

// File: rtl/sobel_stream_gradient.sv
// Streaming 3x3 Sobel gradient: two line buffers build the window, then a two-stage
// pipeline produces a saturated magnitude, an edge flag and an end-of-line marker.
module sobel_stream_gradient #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     thresh,
  input  logic                  mag_mode,
  sobel_stream_gradient_if.slave pix
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SW    = DATA_W + 3;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [SW-1:0]    MAG_MAX  = {3'b000, {DATA_W{1'b1}}};

  logic [COL_W-1:0]  col, eff_col;
  logic [1:0]        row, eff_row;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] up1, up2;
  logic [DATA_W-1:0] win [9];
  logic              v0, eol0, v1, eol1;
  logic [SW-1:0]     gx1, gy1;
  logic [SW-1:0]     px_c, nx_c, py_c, ny_c;
  logic [SW-1:0]     ax_c, ay_c, sum_c, max_c, mag_c;
  logic              sat_c, edge_c;
  logic [DATA_W-1:0] grad_c;

  function automatic logic [SW-1:0] ext(input logic [DATA_W-1:0] p);
    return {3'b000, p};
  endfunction

  // A start-of-frame beat is placed at the origin regardless of the running counters.
  always_comb begin
    eff_col = col;
    eff_row = row;
    if (pix.in_sof) begin
      eff_col = '0;
      eff_row = '0;
    end
    up1 = lb0[eff_col];
    up2 = lb1[eff_col];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix.in_valid) begin
      if (eff_col == COL_LAST) begin
        col <= '0;
        row <= (eff_row == 2'd2) ? eff_row : eff_row + 2'd1;
      end else begin
        col <= eff_col + COL_W'(1);
        row <= eff_row;
      end
    end
  end

  // Line buffers and window hold pure data; row/column gating keeps stale contents out.
  always_ff @(posedge clk) begin
    if (pix.in_valid) begin
      lb1[eff_col] <= up1;
      lb0[eff_col] <= pix.in_pixel;
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= up2;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= up1;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= pix.in_pixel;
    end
  end

  // Gradients are kept as SW-bit two's-complement values.
  always_comb begin
    px_c = ext(win[2]) + (ext(win[5]) << 1) + ext(win[8]);
    nx_c = ext(win[0]) + (ext(win[3]) << 1) + ext(win[6]);
    py_c = ext(win[6]) + (ext(win[7]) << 1) + ext(win[8]);
    ny_c = ext(win[0]) + (ext(win[1]) << 1) + ext(win[2]);
  end

  always_ff @(posedge clk) begin
    gx1 <= px_c - nx_c;
    gy1 <= py_c - ny_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0   <= 1'b0;
      eol0 <= 1'b0;
      v1   <= 1'b0;
      eol1 <= 1'b0;
    end else begin
      v0   <= pix.in_valid && (eff_col >= COL_TWO) && (eff_row == 2'd2);
      eol0 <= pix.in_valid && (eff_col == COL_LAST);
      v1   <= v0;
      eol1 <= eol0;
    end
  end

  always_comb begin
    ax_c   = gx1[SW-1] ? (~gx1 + SW'(1)) : gx1;
    ay_c   = gy1[SW-1] ? (~gy1 + SW'(1)) : gy1;
    sum_c  = ax_c + ay_c;
    max_c  = (ax_c >= ay_c) ? ax_c : ay_c;
    mag_c  = mag_mode ? max_c : sum_c;
    sat_c  = mag_c > MAG_MAX;
    grad_c = sat_c ? {DATA_W{1'b1}} : mag_c[DATA_W-1:0];
    edge_c = grad_c >= thresh;
  end

  // Output data is zeroed between strobes so idle cycles never show a stale result.
  always_ff @(posedge clk) begin
    if (!rst_n || !v1) begin
      pix.out_valid <= 1'b0;
      pix.out_grad  <= '0;
      pix.out_edge  <= 1'b0;
      pix.out_sat   <= 1'b0;
      pix.out_eol   <= 1'b0;
    end else begin
      pix.out_valid <= 1'b1;
      pix.out_grad  <= grad_c;
      pix.out_edge  <= edge_c;
      pix.out_sat   <= sat_c;
      pix.out_eol   <= eol1;
    end
  end

endmodule

// File: tb/tb_sobel_stream_gradient.sv
// Directed bench for sobel_stream_gradient at IMG_W=4 with hand-computed expectations.
module tb_sobel_stream_gradient;

  logic       clk;
  logic       rst_n;
  logic [7:0] thresh;
  logic       mag_mode;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  logic [7:0] frame [4][4];
  logic [7:0] q_grad [$];
  bit         q_edge [$];
  bit         q_sat  [$];
  bit         q_eol  [$];
  int         q_cyc  [$];
  int         exp_acc [$];

  sobel_stream_gradient_if #(.DATA_W(8)) bus ();

  sobel_stream_gradient #(.DATA_W(8), .IMG_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .thresh   (thresh),
    .mag_mode (mag_mode),
    .pix      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output strobe together with the edge index it appeared on.
  always @(posedge clk) begin
    #1;
    if (bus.out_valid === 1'b1) begin
      q_grad.push_back(bus.out_grad);
      q_edge.push_back(bus.out_edge);
      q_sat.push_back(bus.out_sat);
      q_eol.push_back(bus.out_eol);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    q_grad.delete(); q_edge.delete(); q_sat.delete(); q_eol.delete();
    q_cyc.delete(); exp_acc.delete();
  endtask

  task automatic fill_rows(input logic [7:0] a, b, c, d);
    for (int r = 0; r < 4; r++) begin
      frame[r][0] = a; frame[r][1] = b; frame[r][2] = c; frame[r][3] = d;
    end
  endtask

  task automatic send_beat(input logic [7:0] p, input bit sof, input bit completing);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pixel = p;
    bus.in_sof   = sof;
    if (completing) exp_acc.push_back(cyc + 1);
  endtask

  task automatic send_frame(input int rows, input bit sof, input int gap, input bit flush);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < 4; c++) begin
        send_beat(frame[r][c], sof && r == 0 && c == 0, r >= 2 && c >= 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          bus.in_sof   = 1'b0;
        end
      end
    end
    if (flush) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'd77;
    bus.in_sof = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_grad !== 8'd0) begin n_err++; $display("[TB] FAIL reset_grad got %0d want 0", bus.out_grad); end
    n_vec++; if (bus.out_edge !== 1'b0) begin n_err++; $display("[TB] FAIL reset_edge got %b want 0", bus.out_edge); end
    n_vec++; if (bus.out_sat !== 1'b0) begin n_err++; $display("[TB] FAIL reset_sat got %b want 0", bus.out_sat); end
    n_vec++; if (bus.out_eol !== 1'b0) begin n_err++; $display("[TB] FAIL reset_eol got %b want 0", bus.out_eol); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_constant();
    fill_rows(8'd100, 8'd100, 8'd100, 8'd100);
    thresh = 8'd1; mag_mode = 1'b0;
    clear_q();
    send_frame(4, 1'b1, 0, 1'b1);
    n_vec++; if (q_grad.size() !== 4) begin n_err++; $display("[TB] FAIL const_count got %0d want 4", q_grad.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_vec++; if (q_grad[i] !== 8'd0) begin n_err++; $display("[TB] FAIL const_grad[%0d] got %0d want 0", i, q_grad[i]); end
      n_vec++; if (q_edge[i] !== 1'b0 || q_sat[i] !== 1'b0) begin n_err++; $display("[TB] FAIL const_flags[%0d] got edge=%b sat=%b want 0 0", i, q_edge[i], q_sat[i]); end
      n_vec++; if (q_eol[i] !== bit'(i % 2)) begin n_err++; $display("[TB] FAIL const_eol[%0d] got %b want %0d", i, q_eol[i], i % 2); end
    end
  endtask

  task automatic test_vertical_step();
    for (int t = 40; t <= 41; t++) begin
      fill_rows(8'd0, 8'd0, 8'd10, 8'd10);
      thresh = 8'(t); mag_mode = 1'b0;
      clear_q();
      send_frame(3, 1'b1, 0, 1'b1);
      n_vec++; if (q_grad.size() !== 2) begin n_err++; $display("[TB] FAIL vstep_count got %0d want 2", q_grad.size()); end
      else for (int i = 0; i < 2; i++) begin
        n_vec++; if (q_grad[i] !== 8'd40) begin n_err++; $display("[TB] FAIL vstep_grad[%0d] got %0d want 40", i, q_grad[i]); end
        n_vec++; if (q_edge[i] !== (t == 40)) begin n_err++; $display("[TB] FAIL vstep_edge[%0d] thr=%0d got %b want %0d", i, t, q_edge[i], t == 40); end
        n_vec++; if (q_sat[i] !== 1'b0 || q_eol[i] !== bit'(i)) begin n_err++; $display("[TB] FAIL vstep_sat_eol[%0d] got %b %b want 0 %0d", i, q_sat[i], q_eol[i], i); end
        n_vec++; if (q_cyc[i] !== exp_acc[i] + 2) begin n_err++; $display("[TB] FAIL vstep_latency[%0d] got edge %0d want %0d", i, q_cyc[i], exp_acc[i] + 2); end
      end
    end
  endtask

  task automatic test_ramp();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) frame[r][c] = 8'(10 * c + 10 * r);
      thresh = 8'd100; mag_mode = m[0];
      clear_q();
      send_frame(3, 1'b1, 0, 1'b1);
      n_vec++; if (q_grad.size() !== 2) begin n_err++; $display("[TB] FAIL ramp_count mode=%0d got %0d want 2", m, q_grad.size()); end
      else for (int i = 0; i < 2; i++) begin
        n_vec++; if (q_grad[i] !== ((m == 0) ? 8'd160 : 8'd80)) begin n_err++; $display("[TB] FAIL ramp_grad[%0d] mode=%0d got %0d want %0d", i, m, q_grad[i], (m == 0) ? 160 : 80); end
        n_vec++; if (q_edge[i] !== (m == 0) || q_sat[i] !== 1'b0) begin n_err++; $display("[TB] FAIL ramp_flags[%0d] mode=%0d got edge=%b sat=%b", i, m, q_edge[i], q_sat[i]); end
      end
    end
  endtask

  task automatic test_saturation();
    for (int m = 0; m < 2; m++) begin
      fill_rows(8'd0, 8'd0, 8'd255, 8'd255);
      thresh = 8'd255; mag_mode = m[0];
      clear_q();
      send_frame(3, 1'b1, 0, 1'b1);
      n_vec++; if (q_grad.size() !== 2) begin n_err++; $display("[TB] FAIL sat_count mode=%0d got %0d want 2", m, q_grad.size()); end
      else for (int i = 0; i < 2; i++) begin
        n_vec++; if (q_grad[i] !== 8'd255) begin n_err++; $display("[TB] FAIL sat_grad[%0d] mode=%0d got %0d want 255", i, m, q_grad[i]); end
        n_vec++; if (q_sat[i] !== 1'b1 || q_edge[i] !== 1'b1) begin n_err++; $display("[TB] FAIL sat_flags[%0d] mode=%0d got sat=%b edge=%b want 1 1", i, m, q_sat[i], q_edge[i]); end
      end
    end
  endtask

  task automatic test_gapped();
    fill_rows(8'd0, 8'd0, 8'd10, 8'd10);
    thresh = 8'd40; mag_mode = 1'b0;
    clear_q();
    send_frame(3, 1'b1, 2, 1'b1);
    n_vec++; if (q_grad.size() !== 2) begin n_err++; $display("[TB] FAIL gap_count got %0d want 2", q_grad.size()); end
    else for (int i = 0; i < 2; i++) begin
      n_vec++; if (q_grad[i] !== 8'd40 || q_edge[i] !== 1'b1) begin n_err++; $display("[TB] FAIL gap_value[%0d] got grad=%0d edge=%b want 40 1", i, q_grad[i], q_edge[i]); end
      n_vec++; if (q_eol[i] !== bit'(i)) begin n_err++; $display("[TB] FAIL gap_eol[%0d] got %b want %0d", i, q_eol[i], i); end
      n_vec++; if (q_cyc[i] !== exp_acc[i] + 2) begin n_err++; $display("[TB] FAIL gap_latency[%0d] got edge %0d want %0d", i, q_cyc[i], exp_acc[i] + 2); end
    end
  endtask

  task automatic test_sof_midframe();
    thresh = 8'd1; mag_mode = 1'b0;
    clear_q();
    for (int k = 0; k < 6; k++) send_beat(8'd200, k == 0, 1'b0);
    fill_rows(8'd50, 8'd50, 8'd50, 8'd50);
    send_frame(4, 1'b1, 0, 1'b1);
    n_vec++; if (q_grad.size() !== 4) begin n_err++; $display("[TB] FAIL sof_count got %0d want 4", q_grad.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_vec++; if (q_grad[i] !== 8'd0 || q_sat[i] !== 1'b0) begin n_err++; $display("[TB] FAIL sof_grad[%0d] got grad=%0d sat=%b want 0 0", i, q_grad[i], q_sat[i]); end
      n_vec++; if (q_eol[i] !== bit'(i % 2)) begin n_err++; $display("[TB] FAIL sof_eol[%0d] got %b want %0d", i, q_eol[i], i % 2); end
    end
  endtask

  task automatic test_reset_midframe();
    fill_rows(8'd0, 8'd0, 8'd255, 8'd255);
    thresh = 8'd0; mag_mode = 1'b0;
    clear_q();
    send_frame(3, 1'b1, 0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.out_grad !== 8'd0) begin n_err++; $display("[TB] FAIL rstmid_out got valid=%b grad=%0d want 0 0", bus.out_valid, bus.out_grad); end
    n_vec++; if (bus.out_edge !== 1'b0 || bus.out_sat !== 1'b0 || bus.out_eol !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_flags got %b%b%b want 000", bus.out_edge, bus.out_sat, bus.out_eol); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (q_grad.size() !== 0) begin n_err++; $display("[TB] FAIL rstmid_discard got %0d outputs want 0", q_grad.size()); end
    fill_rows(8'd100, 8'd100, 8'd100, 8'd100);
    clear_q();
    send_frame(4, 1'b0, 0, 1'b1);
    n_vec++; if (q_grad.size() !== 4) begin n_err++; $display("[TB] FAIL rstmid_count got %0d want 4", q_grad.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_vec++; if (q_grad[i] !== 8'd0 || q_edge[i] !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_frame[%0d] got grad=%0d edge=%b want 0 1", i, q_grad[i], q_edge[i]); end
      n_vec++; if (q_eol[i] !== bit'(i % 2)) begin n_err++; $display("[TB] FAIL rstmid_eol[%0d] got %b want %0d", i, q_eol[i], i % 2); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    thresh = 8'd0;
    mag_mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = 8'd0;
    bus.in_sof = 1'b0;
    $display("[TB] start");
    test_reset();
    test_constant();
    test_vertical_step();
    test_ramp();
    test_saturation();
    test_gapped();
    test_sof_midframe();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
